count_seq_ctrl: RTL and testbench

COUNT_SEQ_CTRL -- requirements
Module: count_seq_ctrl

---
 rtl/count_ctrl_pkg.sv | 13 +
 rtl/updown_counter.sv | 41 ++++
 rtl/count_seq_ctrl.sv | 99 +++++++++
 tb/tb_count_seq_ctrl.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/count_ctrl_pkg.sv
// Shared types for the counting-sequence controller: FSM state encoding and default width.
package count_ctrl_pkg;

  localparam int DEF_WIDTH = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

endpackage

// File: rtl/updown_counter.sv
// Loadable up/down modulo-2^WIDTH counter; wrap pulses for the cycle after a step crosses the boundary.
module updown_counter
  import count_ctrl_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_load,
  input  logic             i_en,
  input  logic             i_dir,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q,
  output logic             o_wrap
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] r_q;
  logic             r_wrap;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_q    <= '0;
      r_wrap <= 1'b0;
    end else begin
      r_wrap <= 1'b0;
      if (i_load) begin
        r_q <= i_d;
      end else if (i_en) begin
        r_q    <= i_dir ? r_q + ONE : r_q - ONE;
        // wrap flags the step leaving all-ones (up) or all-zeros (down)
        r_wrap <= i_dir ? (&r_q) : ~(|r_q);
      end
    end
  end

  assign o_q    = r_q;
  assign o_wrap = r_wrap;

endmodule

// File: rtl/count_seq_ctrl.sv
// Command-driven counting sequencer: accepts one command, loads, steps N times, pulses done.
module count_seq_ctrl
  import count_ctrl_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_dir,
  input  logic [WIDTH-1:0] cmd_start,
  input  logic [WIDTH:0]   cmd_steps,
  input  logic             abort,
  output logic [WIDTH-1:0] q,
  output logic             busy,
  output logic             done,
  output logic             aborted,
  output logic             wrap
);

  localparam logic [WIDTH:0] REM_ONE = {{WIDTH{1'b0}}, 1'b1};

  state_t           r_state;
  logic             r_dir;
  logic [WIDTH-1:0] r_start;
  logic [WIDTH:0]   r_steps;
  logic [WIDTH:0]   r_remain;
  logic             r_aborted;

  logic w_hs;
  logic w_load;
  logic w_step;

  assign cmd_ready = (r_state == ST_IDLE);
  assign w_hs      = cmd_valid & cmd_ready;
  // abort suppresses the load/step on the same edge
  assign w_load    = (r_state == ST_LOAD) & ~abort;
  assign w_step    = (r_state == ST_RUN) & ~abort;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_dir     <= 1'b0;
      r_start   <= '0;
      r_steps   <= '0;
      r_remain  <= '0;
      r_aborted <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_hs) begin
            r_dir     <= cmd_dir;
            r_start   <= cmd_start;
            r_steps   <= cmd_steps;
            r_aborted <= 1'b0;
            r_state   <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          if (abort) begin
            r_aborted <= 1'b1;
            r_state   <= ST_DONE;
          end else begin
            r_remain <= r_steps;
            r_state  <= (r_steps == '0) ? ST_DONE : ST_RUN;
          end
        end
        ST_RUN: begin
          if (abort) begin
            r_aborted <= 1'b1;
            r_state   <= ST_DONE;
          end else begin
            r_remain <= r_remain - REM_ONE;
            if (r_remain == REM_ONE) r_state <= ST_DONE;
          end
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  updown_counter #(.WIDTH(WIDTH)) u_cnt (
    .clk   (clk),
    .reset (reset),
    .i_load(w_load),
    .i_en  (w_step),
    .i_dir (r_dir),
    .i_d   (r_start),
    .o_q   (q),
    .o_wrap(wrap)
  );

  assign busy    = (r_state != ST_IDLE);
  assign done    = (r_state == ST_DONE);
  assign aborted = done & r_aborted;

endmodule

// File: tb/tb_count_seq_ctrl.sv
// Bench for count_seq_ctrl: directed and random commands against an arithmetic trace model.
module tb_count_seq_ctrl;

  localparam int W = 4;
  localparam int M = 1 << W;

  logic         clk = 1'b0;
  logic         reset;
  logic         cmd_valid;
  logic         cmd_ready;
  logic         cmd_dir;
  logic [W-1:0] cmd_start;
  logic [W:0]   cmd_steps;
  logic         abort;
  logic [W-1:0] q;
  logic         busy;
  logic         done;
  logic         aborted;
  logic         wrap;

  int checks   = 0;
  int failures = 0;
  int mq       = 0;

  always #5 clk = ~clk;

  count_seq_ctrl #(.WIDTH(W)) dut (
    .clk      (clk),
    .reset    (reset),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_dir  (cmd_dir),
    .cmd_start(cmd_start),
    .cmd_steps(cmd_steps),
    .abort    (abort),
    .q        (q),
    .busy     (busy),
    .done     (done),
    .aborted  (aborted),
    .wrap     (wrap)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic samp(input string tag, input int eq, input int ew, input int ed,
                      input int ea, input int eb, input int er);
    chk({tag, ".q"}, 32'(q), eq);
    chk({tag, ".wrap"}, 32'(wrap), ew);
    chk({tag, ".done"}, 32'(done), ed);
    chk({tag, ".aborted"}, 32'(aborted), ea);
    chk({tag, ".busy"}, 32'(busy), eb);
    chk({tag, ".ready"}, 32'(cmd_ready), er);
  endtask

  // Expected trace: q=start after E1, start+/-j after E(1+j); abort at edge a freezes q, ends at a.
  task automatic run_cmd(input string tag, input bit d, input int st, input int n, input int ab_at);
    int f;
    int nq;
    int ew;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_dir   = d;
    cmd_start = W'(st);
    cmd_steps = (W+1)'(n);
    abort     = 1'b0;
    @(posedge clk);
    @(negedge clk);
    samp({tag, ".load"}, mq, 0, 0, 0, 1, 0);
    // garbage while busy must be ignored
    cmd_valid = 1'($urandom_range(0, 1));
    cmd_dir   = 1'($urandom);
    cmd_start = W'($urandom);
    cmd_steps = (W+1)'($urandom_range(0, M));
    f = (ab_at > 0) ? ab_at : n + 1;
    for (int k = 1; k <= f; k++) begin
      abort = (k == ab_at);
      @(posedge clk);
      @(negedge clk);
      ew = 0;
      if (ab_at > 0 && k == f) begin
        // q held
      end else if (k == 1) begin
        mq = st;
      end else begin
        nq = d ? mq + 1 : mq - 1;
        ew = (nq < 0 || nq >= M) ? 1 : 0;
        mq = (nq + M) % M;
      end
      samp($sformatf("%s.e%0d", tag, k), mq, ew, (k == f) ? 1 : 0,
           (k == f && ab_at > 0) ? 1 : 0, 1, 0);
    end
    abort     = 1'($urandom_range(0, 1));
    cmd_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    samp({tag, ".idle"}, mq, 0, 0, 0, 0, 1);
    abort = 1'b0;
  endtask

  initial begin
    int n;
    int ab;
    reset     = 1'b1;
    cmd_valid = 1'b0;
    cmd_dir   = 1'b0;
    cmd_start = '0;
    cmd_steps = '0;
    abort     = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    samp("reset", 0, 0, 0, 0, 0, 1);
    reset = 1'b0;
    mq    = 0;

    run_cmd("up", 1'b1, 3, 4, 0);
    run_cmd("downwrap", 1'b0, 1, 3, 0);
    run_cmd("zero", 1'b1, 9, 0, 0);
    run_cmd("abort", 1'b1, 0, 10, 4);
    run_cmd("full", 1'b1, 5, 16, 0);
    run_cmd("abort_load", 1'b0, 12, 5, 1);
    run_cmd("abort_last", 1'b0, 2, 3, 4);
    run_cmd("full_down", 1'b0, 0, 16, 0);

    // reset in the middle of a run
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_dir   = 1'b1;
    cmd_start = W'(2);
    cmd_steps = (W+1)'(10);
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    abort = 1'b1;
    @(posedge clk);
    @(negedge clk);
    samp("midreset", 0, 0, 0, 0, 0, 1);
    reset = 1'b0;
    abort = 1'b0;
    mq    = 0;
    @(posedge clk);
    @(negedge clk);
    samp("postreset", 0, 0, 0, 0, 0, 1);
    run_cmd("after_reset", 1'b0, 7, 2, 0);

    for (int i = 0; i < 30; i++) begin
      n  = $urandom_range(0, M);
      ab = ($urandom_range(0, 2) == 0) ? $urandom_range(1, n + 1) : 0;
      run_cmd($sformatf("rnd%0d", i), 1'($urandom), $urandom_range(0, M - 1), n, ab);
      repeat ($urandom_range(0, 2)) begin
        @(negedge clk);
        abort = 1'($urandom);
        @(posedge clk);
        @(negedge clk);
        samp($sformatf("gap%0d", i), mq, 0, 0, 0, 0, 1);
        abort = 1'b0;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
